// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types for the UART frame receive path: frame FSM states and byte type.
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        FRAME_IDLE,
        FRAME_LEN,
        FRAME_PAYLOAD,
        FRAME_CSUM,
        FRAME_DRAIN,
        FRAME_RESTART
    } frame_state_e;

endpackage

// File: rtl/uart_frame_buf.sv
`timescale 1ns/1ps
// Payload register file: synchronous write, combinational read.
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          tick,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata_c
);

    byte_t mem [DEPTH];

    always_ff @(posedge tick) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
`timescale 1ns/1ps
// Frame controller behind the UART byte receiver: parses SYNC/LEN/PAYLOAD/CSUM,
// verifies the XOR checksum and streams verified payloads over valid/ready.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter byte_t       SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned TIMEOUT_TICKS = 512
) (
    input  logic       tick,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

    logic         rx_done_q;
    logic         strobe;
    byte_t        rx_byte;

    frame_state_e state, state_d;
    byte_t        len, len_d;
    byte_t        idx, idx_d;
    byte_t        chk, chk_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic         rx_en_d, valid_d, last_d, ok_d, err_d, ovr_d;
    byte_t        data_d;

    logic          buf_we_c;
    logic [AW-1:0] buf_raddr_c;
    byte_t         buf_rdata_c;
    logic          timeout_c;

    // Rising edge of rx_done becomes a one-tick strobe with its byte captured alongside.
    always_ff @(posedge tick or negedge reset) begin
        if (!reset) begin
            rx_done_q <= 1'b0;
            strobe    <= 1'b0;
            rx_byte   <= '0;
        end else begin
            rx_done_q <= rx_done;
            strobe    <= rx_done & ~rx_done_q;
            if (rx_done & ~rx_done_q) rx_byte <= rx_data;
        end
    end

    uart_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
        .tick    (tick),
        .we      (buf_we_c),
        .waddr   (AW'(idx)),
        .wdata   (rx_byte),
        .raddr   (buf_raddr_c),
        .rdata_c (buf_rdata_c)
    );

    // Prefetch the byte that becomes out_data on the next handshake (index 0 on entry).
    assign buf_raddr_c = (state == FRAME_DRAIN) ? AW'(idx + 8'd1) : '0;
    assign timeout_c   = !strobe && (tcnt == TW'(TIMEOUT_TICKS - 1));

    always_comb begin
        state_d  = state;
        len_d    = len;
        idx_d    = idx;
        chk_d    = chk;
        tcnt_d   = tcnt;
        buf_we_c = 1'b0;
        valid_d  = out_valid;
        last_d   = out_last;
        data_d   = out_data;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        ovr_d    = overrun;

        case (state)
            FRAME_IDLE: begin
                tcnt_d = '0;
                if (strobe && rx_byte == SYNC_BYTE) state_d = FRAME_LEN;
            end
            FRAME_LEN: begin
                tcnt_d = tcnt + TW'(1);
                if (strobe) begin
                    tcnt_d = '0;
                    if (rx_byte == 8'd0 || rx_byte > 8'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        state_d = FRAME_RESTART;
                    end else begin
                        len_d   = rx_byte;
                        chk_d   = rx_byte;
                        idx_d   = '0;
                        state_d = FRAME_PAYLOAD;
                    end
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = FRAME_RESTART;
                end
            end
            FRAME_PAYLOAD: begin
                tcnt_d = tcnt + TW'(1);
                if (strobe) begin
                    tcnt_d   = '0;
                    buf_we_c = 1'b1;
                    chk_d    = chk ^ rx_byte;
                    idx_d    = idx + 8'd1;
                    if (idx_d == len) state_d = FRAME_CSUM;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = FRAME_RESTART;
                end
            end
            FRAME_CSUM: begin
                tcnt_d = tcnt + TW'(1);
                if (strobe) begin
                    tcnt_d = '0;
                    if (rx_byte == chk) begin
                        ok_d    = 1'b1;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        data_d  = buf_rdata_c;
                        last_d  = (len == 8'd1);
                        state_d = FRAME_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FRAME_RESTART;
                    end
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = FRAME_RESTART;
                end
            end
            FRAME_DRAIN: begin
                tcnt_d = '0;
                if (strobe) ovr_d = 1'b1;
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = FRAME_IDLE;
                    end else begin
                        idx_d  = idx + 8'd1;
                        data_d = buf_rdata_c;
                        last_d = (idx_d == len - 8'd1);
                    end
                end
            end
            FRAME_RESTART: begin
                tcnt_d  = '0;
                state_d = FRAME_IDLE;
            end
            default: state_d = FRAME_IDLE;
        endcase

        rx_en_d = (state_d != FRAME_RESTART);
    end

    always_ff @(posedge tick or negedge reset) begin
        if (!reset) begin
            state     <= FRAME_IDLE;
            len       <= '0;
            idx       <= '0;
            chk       <= '0;
            tcnt      <= '0;
            rx_en     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            len       <= len_d;
            idx       <= idx_d;
            chk       <= chk_d;
            tcnt      <= tcnt_d;
            rx_en     <= rx_en_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            overrun   <= ovr_d;
        end
    end

endmodule
